ex_mem_latch: RTL and testbench
===============================

# ex_mem_latch

EX/MEM pipeline boundary register between the execute stage and the memory stage. Captures one instruction's execute results and memory/write-back controls per accepted transfer and presents them to the memory stage under a valid/ready handshake. Supports stall (back-pressure), flush (squash), sticky halt, and a saturating stall counter. An optional skid entry allows full throughput with a registered `in_ready`.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low. Asserting `rst` = 0 immediately applies reset state.
- `in_valid`  in  1  execute stage presents a valid instruction.
- `in_ready`  out  1  block accepts on this cycle.
- `in_pc_add`, `in_imm8_ext`, `in_imm11_ext`, `in_alu_result`, `in_write_data`  in  16 each  execute results and operands.
- `in_imm_src`, `in_alu_jump`, `in_brch_cnd`, `in_mem_read`, `in_mem_write`, `in_reg_write`, `in_mem_to_reg`, `in_halt`  in  1 each  control bits.
- `in_wb_reg`  in  3  destination register.
- `out_*`  out  same widths as `in_*`  registered copies of the held entry.
- `out_valid`  out  1  held entry valid.
- `out_ready`  in  1  memory stage consumes on this cycle.
- `flush`  in  1  synchronous squash of all held and incoming entries.
- `halt_seen`  out  1  sticky; a halt entry was delivered downstream.
- `stall_cnt`  out  16  saturating count of stalled cycles.

## Operation
- **Transfers:**
  - Input transfer = `in_valid & in_ready`.
  - Output transfer = `out_valid & out_ready`.
- **Output stability:** while `out_valid & ~out_ready`, all `out_*` hold stable.
- **Main entry:**
  - Loads on an input transfer when empty or draining (output transfer the same cycle).
  - Otherwise the input is routed per Configuration.
- **Flush:**
  - At the clock edge where `flush` = 1, every held entry becomes invalid.
  - An input transfer in the same cycle is discarded.
  - `out_valid` = 0 next cycle.
  - `halt_seen` and `stall_cnt` are unaffected.
- **Halt:**
  - On an output transfer with `out_halt` = 1 (and no flush), `halt_seen` sets.
  - Any skid entry is discarded; `out_valid` clears next cycle.
  - From then on `in_ready` = 0 until reset.
- **Stall counter:**
  - Increments each cycle `out_valid & ~out_ready & ~flush`.
  - Saturates at 16'hFFFF.
- **Output gating:** data outputs are not gated by `out_valid`; consumers qualify with `out_valid`.

## Timing
- **Reset values:**
  - `out_valid` = 0, all `out_*` data/control = 0, `halt_seen` = 0, `stall_cnt` = 0.
  - `in_ready` = 1 in both configurations.
- **Latency:** one cycle; an entry accepted at edge N is presented with `out_valid` = 1 after edge N.
- **Throughput:** one entry per cycle while `out_ready` = 1.
- **Reset mid-operation:** all entries are lost and no partial state is kept; `in_ready` returns to 1 during reset.
- **Flush vs halt:** when `flush` and a halt output transfer coincide, flush wins and `halt_seen` does not set.

## Configuration
- Macro: `EX_MEM_SKID_EN`.
- **Defined:**
  - A second (skid) entry exists.
  - `in_ready` is a register output: `~halt_seen & ~skid_valid`.
  - An input accepted while the main entry is full and not draining goes to skid; `in_ready` drops next cycle.
  - On main drain, skid moves to main in the same edge.
  - Order is always preserved.
- **Undefined:**
  - Single entry only.
  - `in_ready` is combinational: `~halt_seen & (~out_valid | out_ready)`.
  - Same latency and reset values.

## Test plan
- **Basic pass-through:** reset, then `in_valid` = 1 with `in_alu_result` = 16'h1234, `out_ready` = 1 → next cycle `out_valid` = 1, `out_alu_result` = 16'h1234; 8 back-to-back entries emerge in order, one per cycle.
- **Back-pressure:**
  - Setup: hold `out_ready` = 0 for 5 cycles with entry A held.
  - `out_*` stay equal to A throughout.
  - `stall_cnt` reads 5.
  - With skid, exactly one extra entry B is accepted and emerges after A.
- **Flush:** `flush` = 1 while full (and skid full) with `in_valid` = 1 → next cycle `out_valid` = 0; none of the flushed or incoming entries ever appear.
- **Halt:**
  - Stimulus: deliver an entry with `in_halt` = 1 followed by entry C.
  - After the halt output transfer, `halt_seen` = 1.
  - `in_ready` = 0 and `out_valid` = 0 thereafter.
  - C never appears.
- **Async reset mid-stream:** drop `rst` to 0 between clock edges while `out_valid` = 1 → `out_valid` = 0 and `stall_cnt` = 0 immediately, without waiting for a clock edge.
- **Saturation:** preload stall for 65 540 cycles → `stall_cnt` = 16'hFFFF and holds.

Source files
------------

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline boundary register with valid/ready handshake,
// flush, sticky halt and a saturating stall counter.
// Optional skid entry (registered in_ready) is enabled by `define EX_MEM_SKID_EN.
module ex_mem_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_pc_add,
  input  logic [15:0] in_imm8_ext,
  input  logic [15:0] in_imm11_ext,
  input  logic [15:0] in_alu_result,
  input  logic [15:0] in_write_data,
  input  logic        in_imm_src,
  input  logic        in_alu_jump,
  input  logic        in_brch_cnd,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic        in_halt,
  input  logic [2:0]  in_wb_reg,
  output logic [15:0] out_pc_add,
  output logic [15:0] out_imm8_ext,
  output logic [15:0] out_imm11_ext,
  output logic [15:0] out_alu_result,
  output logic [15:0] out_write_data,
  output logic        out_imm_src,
  output logic        out_alu_jump,
  output logic        out_brch_cnd,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic        out_mem_to_reg,
  output logic        out_halt,
  output logic [2:0]  out_wb_reg,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic        halt_seen,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic [15:0] pc_add;
    logic [15:0] imm8_ext;
    logic [15:0] imm11_ext;
    logic [15:0] alu_result;
    logic [15:0] write_data;
    logic        imm_src;
    logic        alu_jump;
    logic        brch_cnd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        halt;
    logic [2:0]  wb_reg;
  } entry_t;

  entry_t      in_e;
  entry_t      main_q, main_d;
  logic        main_valid_q, main_valid_d;
  logic        halt_seen_q, halt_seen_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        in_xfer, out_xfer, drain, halt_fire;
`ifdef EX_MEM_SKID_EN
  entry_t      skid_q, skid_d;
  logic        skid_valid_q, skid_valid_d;
`endif

  assign in_e = '{pc_add: in_pc_add, imm8_ext: in_imm8_ext, imm11_ext: in_imm11_ext,
                  alu_result: in_alu_result, write_data: in_write_data,
                  imm_src: in_imm_src, alu_jump: in_alu_jump, brch_cnd: in_brch_cnd,
                  mem_read: in_mem_read, mem_write: in_mem_write, reg_write: in_reg_write,
                  mem_to_reg: in_mem_to_reg, halt: in_halt, wb_reg: in_wb_reg};

  // Acceptance: registered with skid, combinational pass-through otherwise.
`ifdef EX_MEM_SKID_EN
  assign in_ready = ~halt_seen_q & ~skid_valid_q;
`else
  assign in_ready = ~halt_seen_q & (~main_valid_q | out_ready);
`endif

  // Next-state: flush/halt squash everything, otherwise load main (from skid first) or park in skid.
  always_comb begin
    in_xfer      = in_valid & in_ready;
    out_xfer     = main_valid_q & out_ready;
    drain        = ~main_valid_q | out_ready;
    halt_fire    = out_xfer & main_q.halt & ~flush;
    main_d       = main_q;
    main_valid_d = main_valid_q;
`ifdef EX_MEM_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
`endif
    halt_seen_d  = halt_seen_q | halt_fire;
    stall_cnt_d  = stall_cnt_q;
    if (main_valid_q & ~out_ready & ~flush & (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;

    if (flush | halt_fire) begin
      main_valid_d = 1'b0;
`ifdef EX_MEM_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (drain) begin
      // Skid holds the older entry, so it always wins over a new input.
`ifdef EX_MEM_SKID_EN
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else
`endif
      if (in_xfer) begin
        main_d       = in_e;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end
`ifdef EX_MEM_SKID_EN
    else if (in_xfer) begin
      skid_d       = in_e;
      skid_valid_d = 1'b1;
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      halt_seen_q  <= 1'b0;
      stall_cnt_q  <= '0;
`ifdef EX_MEM_SKID_EN
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
`endif
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      halt_seen_q  <= halt_seen_d;
      stall_cnt_q  <= stall_cnt_d;
`ifdef EX_MEM_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
`endif
    end
  end

  assign out_pc_add     = main_q.pc_add;
  assign out_imm8_ext   = main_q.imm8_ext;
  assign out_imm11_ext  = main_q.imm11_ext;
  assign out_alu_result = main_q.alu_result;
  assign out_write_data = main_q.write_data;
  assign out_imm_src    = main_q.imm_src;
  assign out_alu_jump   = main_q.alu_jump;
  assign out_brch_cnd   = main_q.brch_cnd;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_to_reg = main_q.mem_to_reg;
  assign out_halt       = main_q.halt;
  assign out_wb_reg     = main_q.wb_reg;
  assign out_valid      = main_valid_q;
  assign halt_seen      = halt_seen_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch: randomized and directed checks of ex_mem_latch against a
// queue-based reference model (capacity 2 when EX_MEM_SKID_EN is defined).
module tb_ex_mem_latch;

  typedef struct packed {
    logic [15:0] pc_add, imm8, imm11, alu, wdata;
    logic        imm_src, alu_jump, brch, mrd, mwr, rw, m2r, halt;
    logic [2:0]  wb;
  } entry_t;

`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  entry_t din = '0;
  logic in_ready, out_valid, halt_seen;
  logic [15:0] stall_cnt;
  logic [15:0] o_pc, o_i8, o_i11, o_alu, o_wd;
  logic o_isrc, o_aj, o_bc, o_mr, o_mw, o_rw, o_m2r, o_halt;
  logic [2:0] o_wb;
  entry_t obs;

  assign obs = {o_pc, o_i8, o_i11, o_alu, o_wd, o_isrc, o_aj, o_bc, o_mr, o_mw, o_rw, o_m2r, o_halt, o_wb};

  always #5 clk = ~clk;

  ex_mem_latch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_add(din.pc_add), .in_imm8_ext(din.imm8), .in_imm11_ext(din.imm11),
    .in_alu_result(din.alu), .in_write_data(din.wdata),
    .in_imm_src(din.imm_src), .in_alu_jump(din.alu_jump), .in_brch_cnd(din.brch),
    .in_mem_read(din.mrd), .in_mem_write(din.mwr), .in_reg_write(din.rw),
    .in_mem_to_reg(din.m2r), .in_halt(din.halt), .in_wb_reg(din.wb),
    .out_pc_add(o_pc), .out_imm8_ext(o_i8), .out_imm11_ext(o_i11),
    .out_alu_result(o_alu), .out_write_data(o_wd),
    .out_imm_src(o_isrc), .out_alu_jump(o_aj), .out_brch_cnd(o_bc),
    .out_mem_read(o_mr), .out_mem_write(o_mw), .out_reg_write(o_rw),
    .out_mem_to_reg(o_m2r), .out_halt(o_halt), .out_wb_reg(o_wb),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .halt_seen(halt_seen), .stall_cnt(stall_cnt)
  );

  // Reference model: ordered queue of held entries.
  entry_t      q[$];
  bit          halted;
  int unsigned exp_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic bit model_ready();
    if (halted) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic entry_t rand_entry();
    entry_t e;
    e.pc_add = 16'($urandom);
    e.imm8   = 16'($urandom);
    e.imm11  = 16'($urandom);
    e.alu    = 16'($urandom);
    e.wdata  = 16'($urandom);
    {e.imm_src, e.alu_jump, e.brch, e.mrd, e.mwr, e.rw, e.m2r} = 7'($urandom);
    e.halt   = 1'b0;
    e.wb     = 3'($urandom);
    return e;
  endfunction

  function automatic bit exp_valid();
    return q.size() > 0;
  endfunction

  // One clock edge: applies the model's transfer rules with the inputs present at the edge.
  task automatic step(output bit acc);
    bit     ixfer = in_valid && model_ready();
    bit     oxfer = (q.size() > 0) && out_ready;
    bit     fl    = flush;
    entry_t inc   = din;
    bit     hit   = 1'b0;
    acc = 1'b0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && !out_ready && exp_cnt < 65535) exp_cnt++;
      if (oxfer) begin
        hit = q[0].halt;
        void'(q.pop_front());
      end
      if (hit) begin
        halted = 1'b1;
        q.delete();
      end else if (ixfer) begin
        q.push_back(inc);
        acc = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; din = '0;
    q.delete(); halted = 1'b0; exp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bit a;
    rst = 1'b0;
    q.delete(); halted = 1'b0; exp_cnt = 0;
    #3;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", obs); end
    n_checks++; if (halt_seen !== 1'b0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_status: got halt %0b cnt %0d want 0 0", halt_seen, stall_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    @(negedge clk); rst = 1'b1;
    step(a);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got valid %0b ready %0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_pass_through();
    bit a;
    entry_t sent[$];
    do_reset();
    din = rand_entry(); din.alu = 16'h1234;
    in_valid = 1'b1; out_ready = 1'b1;
    step(a);
    n_checks++; if (out_valid !== 1'b1 || o_alu !== 16'h1234) begin n_fail++; $display("FAIL pass_first: got valid %0b alu %h want 1 1234", out_valid, o_alu); end
    for (int i = 0; i < 8; i++) begin
      din = rand_entry();
      sent.push_back(din);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pass_ready[%0d]: got %0b want 1", i, in_ready); end
      step(a);
      n_checks++; if (out_valid !== 1'b1 || obs !== sent[i]) begin n_fail++; $display("FAIL pass_order[%0d]: got %0b %h want 1 %h", i, out_valid, obs, sent[i]); end
    end
    in_valid = 1'b0;
    step(a);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    bit a, b_taken;
    entry_t ea, eb, ec;
    do_reset();
    ea = rand_entry(); eb = rand_entry(); ec = rand_entry();
    din = ea; in_valid = 1'b1; out_ready = 1'b0;
    step(a);
    din = eb; b_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (in_ready !== model_ready()) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b want %0b", i, in_ready, model_ready()); end
      step(a);
      if (a) begin
        n_checks++; if (b_taken) begin n_fail++; $display("FAIL bp_extra: got second accept want at most one"); end
        b_taken = 1'b1; din = ec;
      end
      n_checks++; if (out_valid !== 1'b1 || obs !== ea) begin n_fail++; $display("FAIL bp_hold[%0d]: got %0b %h want 1 %h", i, out_valid, obs, ea); end
    end
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
    n_checks++; if (b_taken !== (CAP == 2)) begin n_fail++; $display("FAIL bp_skid_accept: got %0b want %0b", b_taken, CAP == 2); end
    in_valid = 1'b0; out_ready = 1'b1;
    if (!b_taken) begin din = eb; in_valid = 1'b1; end
    step(a);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || obs !== eb) begin n_fail++; $display("FAIL bp_b_after_a: got %0b %h want 1 %h", out_valid, obs, eb); end
    step(a);
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_end: got %0b cnt %0d want 0 5", out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    bit a;
    int cnt_before;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin din = rand_entry(); step(a); end
    n_checks++; if (q.size() != CAP) begin n_fail++; $display("FAIL flush_fill: model holds %0d want %0d", q.size(), CAP); end
    cnt_before = int'(stall_cnt);
    din = rand_entry(); flush = 1'b1;
    step(a);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    n_checks++; if (stall_cnt !== 16'(cnt_before) || halt_seen !== 1'b0) begin n_fail++; $display("FAIL flush_status: got cnt %0d halt %0b want %0d 0", stall_cnt, halt_seen, cnt_before); end
    for (int i = 0; i < 4; i++) begin
      step(a);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d]: got %0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_random();
    bit a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      din = rand_entry();
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 15) == 0);
      #1;
      n_checks++; if (in_ready !== model_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, in_ready, model_ready()); end
      step(a);
      n_checks++; if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, out_valid, exp_valid()); end
      if (q.size() > 0) begin
        n_checks++; if (obs !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, obs, q[0]); end
      end
      n_checks++; if (stall_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); end
    end
    flush = 1'b0;
  endtask

  task automatic test_halt();
    bit a;
    entry_t eh, ecc;
    // Flush coinciding with halt delivery wins.
    do_reset();
    eh = rand_entry(); eh.halt = 1'b1;
    din = eh; in_valid = 1'b1; out_ready = 1'b1;
    step(a);
    in_valid = 1'b0; flush = 1'b1;
    step(a);
    flush = 1'b0;
    n_checks++; if (halt_seen !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_flush_wins: got halt %0b valid %0b want 0 0", halt_seen, out_valid); end
    // Normal halt delivery followed by entry C.
    do_reset();
    ecc = rand_entry();
    din = eh; in_valid = 1'b1; out_ready = 1'b1;
    step(a);
    n_checks++; if (halt_seen !== 1'b0 || out_valid !== 1'b1 || obs !== eh) begin n_fail++; $display("FAIL halt_pre: got halt %0b valid %0b %h want 0 1 %h", halt_seen, out_valid, obs, eh); end
    din = ecc;
    for (int i = 0; i < 6; i++) begin
      step(a);
      n_checks++; if (halt_seen !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_post[%0d]: got halt %0b valid %0b ready %0b want 1 0 0", i, halt_seen, out_valid, in_ready); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit a;
    do_reset();
    din = rand_entry(); in_valid = 1'b1; out_ready = 1'b0;
    step(a); in_valid = 1'b0;
    step(a); step(a);
    n_checks++; if (out_valid !== 1'b1 || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL arst_pre: got %0b cnt %0d want 1 2", out_valid, stall_cnt); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || in_ready !== 1'b1 || obs !== '0) begin n_fail++; $display("FAIL arst_now: got valid %0b cnt %0d ready %0b data %h want 0 0 1 0", out_valid, stall_cnt, in_ready, obs); end
    q.delete(); halted = 1'b0; exp_cnt = 0;
    @(negedge clk); rst = 1'b1;
    step(a);
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_after: got %0b cnt %0d want 0 0", out_valid, stall_cnt); end
  endtask

  task automatic test_saturation();
    bit a;
    do_reset();
    din = rand_entry(); in_valid = 1'b1; out_ready = 1'b0;
    step(a); in_valid = 1'b0;
    for (int i = 0; i < 65540; i++) step(a);
    n_checks++; if (stall_cnt !== 16'hFFFF || exp_cnt != 65535) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", stall_cnt); end
    for (int i = 0; i < 3; i++) step(a);
    n_checks++; if (stall_cnt !== 16'hFFFF || out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got %h valid %0b want ffff 1", stall_cnt, out_valid); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_back_pressure();
    test_flush();
    test_random();
    test_halt();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
